// File: rtl/depacketizer.sv
// depacketizer: receive side of the three-flit packet link (head, body, tail).
// Pops flits from the flit FIFO one at a time and checks each flit against the
// format expected in the current state. Payloads addressed to this node go out
// through a ready/valid sink. Format errors are reported, and the walker then
// resynchronises on the next valid head.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   local_addr     this node's address, sampled when a head is evaluated
//   fifo_empty     flit FIFO empty flag
//   fifo_rd_en     FIFO pop; the flit appears on flit_in the next cycle
//   flit_in        256-bit flit, valid one cycle after fifo_rd_en
//   data_out       delivered 16-bit payload
//   src_out        source address of the delivered payload
//   data_valid     data_out/src_out valid, held until data_ready
//   data_ready     sink ready
//   err_pulse      one-cycle strobe on a format error
//   err_code       last error (01 head, 10 body, 11 tail), held until the next error
//   pkt_ok_count   saturating count of packets delivered and closed by a good tail
//   pkt_drop_count saturating count of packets filtered or aborted
module depacketizer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       local_addr,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [255:0]     flit_in,
    output logic [15:0]      data_out,
    output logic [7:0]       src_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] pkt_ok_count,
    output logic [CNT_W-1:0] pkt_drop_count
);

    typedef enum logic [1:0] {
        S_HEAD,
        S_BODY,
        S_TAIL
    } state_t;

    state_t     state;
    logic       rd_pending;
    logic       drop;
    logic [7:0] src_q;

    logic head_ok;
    logic body_ok;
    logic tail_ok;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        head_ok = (flit_in[255:248] == 8'h00) && (flit_in[231:0] == '0);
        body_ok = 1'b1;
        for (int unsigned i = 1; i < 16; i++) begin
            if (flit_in[16*i +: 16] != flit_in[15:0]) begin
                body_ok = 1'b0;
            end
        end
        tail_ok = (flit_in == {240'b0, 16'hFFFF});
    end

    // Combinational so a pop can be issued in the very cycle the sink handshakes.
    // Gated by reset so the output reads 0 while reset is held.
    assign fifo_rd_en = reset && !fifo_empty && !rd_pending && (!data_valid || data_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_HEAD;
            rd_pending     <= 1'b0;
            drop           <= 1'b0;
            src_q          <= '0;
            data_out       <= '0;
            src_out        <= '0;
            data_valid     <= 1'b0;
            err_pulse      <= 1'b0;
            err_code       <= 2'b00;
            pkt_ok_count   <= '0;
            pkt_drop_count <= '0;
        end else begin
            rd_pending <= fifo_rd_en;
            err_pulse  <= 1'b0;

            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            // rd_pending marks the cycle in which flit_in carries the popped flit.
            if (rd_pending) begin
                case (state)
                    S_HEAD: begin
                        if (head_ok) begin
                            src_q <= flit_in[247:240];
                            drop  <= (flit_in[239:232] != local_addr);
                            state <= S_BODY;
                        end else begin
                            err_pulse <= 1'b1;
                            err_code  <= 2'b01;
                        end
                    end
                    S_BODY: begin
                        if (body_ok) begin
                            if (!drop) begin
                                data_out   <= flit_in[15:0];
                                src_out    <= src_q;
                                data_valid <= 1'b1;
                            end
                            state <= S_TAIL;
                        end else begin
                            err_pulse      <= 1'b1;
                            err_code       <= 2'b10;
                            pkt_drop_count <= sat_inc(pkt_drop_count);
                            drop           <= 1'b0;
                            state          <= S_HEAD;
                        end
                    end
                    S_TAIL: begin
                        if (tail_ok) begin
                            if (drop) begin
                                pkt_drop_count <= sat_inc(pkt_drop_count);
                            end else begin
                                pkt_ok_count <= sat_inc(pkt_ok_count);
                            end
                        end else begin
                            err_pulse      <= 1'b1;
                            err_code       <= 2'b11;
                            pkt_drop_count <= sat_inc(pkt_drop_count);
                        end
                        drop  <= 1'b0;
                        state <= S_HEAD;
                    end
                    default: begin
                        drop  <= 1'b0;
                        state <= S_HEAD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_depacketizer.sv
// Testbench for depacketizer: directed scenarios followed by randomized packet
// traffic. Expected payloads and error codes are queued by a reference model
// at the moment each flit is pushed into the FIFO. A separate monitor pops
// and compares them whenever the DUT presents a handshake or an error strobe.
module tb_depacketizer;

    localparam int unsigned CW  = 4;
    localparam int          SAT = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [7:0]      local_addr = 8'h22;
    logic            fifo_empty = 1'b1;
    logic            fifo_rd_en;
    logic [255:0]    flit_in = '0;
    logic [15:0]     data_out;
    logic [7:0]      src_out;
    logic            data_valid;
    logic            data_ready = 1'b0;
    logic            err_pulse;
    logic [1:0]      err_code;
    logic [CW-1:0]   pkt_ok_count;
    logic [CW-1:0]   pkt_drop_count;

    depacketizer #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .local_addr(local_addr),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .flit_in(flit_in),
        .data_out(data_out), .src_out(src_out), .data_valid(data_valid),
        .data_ready(data_ready), .err_pulse(err_pulse), .err_code(err_code),
        .pkt_ok_count(pkt_ok_count), .pkt_drop_count(pkt_drop_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // FIFO contents, scoreboard queues and reference-model state
    logic [255:0] fq[$];
    logic [23:0]  exp_data[$];
    logic [1:0]   exp_err[$];
    int           m_pos = 0;     // 0 expect head, 1 expect body, 2 expect tail
    bit           m_drop = 0;
    logic [7:0]   m_src = '0;
    int           m_ok = 0;
    int           m_dropc = 0;
    logic [1:0]   m_last_err = 2'b00;

    int ready_mode = 1;  // 0 random, 1 always ready, 2 stalled
    bit bubble_en  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: classifies each flit by the field rules of the packet format.
    task automatic model_flit(input logic [255:0] f);
        logic [255:0] hdr_fields;
        logic [255:0] tail_word;
        bit is_head, is_body, is_tail;
        hdr_fields = '0;
        hdr_fields[247:232] = 16'hFFFF;
        tail_word = '0;
        tail_word[15:0] = 16'hFFFF;
        is_head = ((f & ~hdr_fields) == '0);
        is_body = (f == {16{f[15:0]}});
        is_tail = (f == tail_word);
        if (m_pos == 0) begin
            if (is_head) begin
                m_src  = f[247:240];
                m_drop = (f[239:232] != local_addr);
                m_pos  = 1;
            end else begin
                exp_err.push_back(2'b01);
                m_last_err = 2'b01;
            end
        end else if (m_pos == 1) begin
            if (is_body) begin
                if (!m_drop) exp_data.push_back({m_src, f[15:0]});
                m_pos = 2;
            end else begin
                exp_err.push_back(2'b10);
                m_last_err = 2'b10;
                m_dropc = (m_dropc < SAT) ? m_dropc + 1 : SAT;
                m_pos = 0;
            end
        end else begin
            if (is_tail) begin
                if (m_drop) m_dropc = (m_dropc < SAT) ? m_dropc + 1 : SAT;
                else        m_ok    = (m_ok < SAT) ? m_ok + 1 : SAT;
            end else begin
                exp_err.push_back(2'b11);
                m_last_err = 2'b11;
                m_dropc = (m_dropc < SAT) ? m_dropc + 1 : SAT;
            end
            m_pos = 0;
        end
    endtask

    task automatic send(input logic [255:0] f);
        model_flit(f);
        fq.push_back(f);
    endtask

    function automatic logic [255:0] mk_head(input logic [7:0] src, input logic [7:0] dest);
        logic [255:0] f;
        f = '0;
        f[247:240] = src;
        f[239:232] = dest;
        return f;
    endfunction

    function automatic logic [255:0] mk_tail();
        logic [255:0] f;
        f = '0;
        f[15:0] = 16'hFFFF;
        return f;
    endfunction

    task automatic send_pkt(input logic [7:0] src, input logic [7:0] dest, input logic [15:0] p);
        send(mk_head(src, dest));
        send({16{p}});
        send(mk_tail());
    endtask

    // FIFO model: pop on the clock edge that sees fifo_rd_en
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fq.size() == 0) begin
                errors++;
                $display("FAIL fifo_underflow: got pop expected no pop");
            end else begin
                flit_in <= fq.pop_front();
            end
        end
    end

    // Input driver: updates sink readiness and FIFO flag just after each edge
    always @(posedge clk) begin
        #2;
        fifo_empty = (fq.size() == 0) || (bubble_en && ($urandom_range(0, 3) == 0));
        case (ready_mode)
            0:       data_ready = ($urandom_range(0, 2) != 0);
            1:       data_ready = 1'b1;
            default: data_ready = 1'b0;
        endcase
    end

    // Monitor: compares DUT outputs against the scoreboard queues
    always @(negedge clk) begin
        if (reset) begin
            if (data_valid && data_ready) begin
                checks++;
                if (exp_data.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_data: got %0h/%0h expected none", src_out, data_out);
                end else begin
                    logic [23:0] e;
                    e = exp_data.pop_front();
                    if ({src_out, data_out} !== e) begin
                        errors++;
                        $display("FAIL data: got %0h expected %0h", {src_out, data_out}, e);
                    end
                end
            end
            if (err_pulse) begin
                checks++;
                if (exp_err.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_err: got code %0d expected none", err_code);
                end else begin
                    logic [1:0] ec;
                    ec = exp_err.pop_front();
                    if (err_code !== ec) begin
                        errors++;
                        $display("FAIL err_code_pulse: got %0d expected %0d", err_code, ec);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < 1000) begin
            @(negedge clk);
            n++;
            if (fq.size() == 0 && !data_valid && !fifo_rd_en) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy expected idle within 1000 cycles");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
        chk({tag, "_data_out"}, 32'(data_out), 0);
        chk({tag, "_src_out"}, 32'(src_out), 0);
        chk({tag, "_valid"}, 32'(data_valid), 0);
        chk({tag, "_err_pulse"}, 32'(err_pulse), 0);
        chk({tag, "_err_code"}, 32'(err_code), 0);
        chk({tag, "_ok_cnt"}, 32'(pkt_ok_count), 0);
        chk({tag, "_drop_cnt"}, 32'(pkt_drop_count), 0);
    endtask

    task automatic model_reset();
        m_pos = 0; m_drop = 0; m_ok = 0; m_dropc = 0; m_last_err = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_ok_cnt"}, 32'(pkt_ok_count), 32'(m_ok));
        chk({tag, "_drop_cnt"}, 32'(pkt_drop_count), 32'(m_dropc));
        chk({tag, "_err_code"}, 32'(err_code), 32'(m_last_err));
        chk({tag, "_data_left"}, 32'(exp_data.size()), 0);
        chk({tag, "_err_left"}, 32'(exp_err.size()), 0);
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1);
    end

    initial begin
        // Reset state
        @(negedge clk);
        check_reset_outputs("init");
        @(negedge clk);
        reset = 1'b1;

        // Good packet
        send_pkt(8'h11, 8'h22, 16'hA5C3);
        wait_idle();
        check_state("good");
        chk("good_ok_is_1", 32'(pkt_ok_count), 1);

        // Address filter
        do_reset();
        send_pkt(8'h11, 8'h33, 16'hA5C3);
        wait_idle();
        check_state("filter");
        chk("filter_drop_is_1", 32'(pkt_drop_count), 1);

        // Body error: lane 7 zeroed, then tail seen as a bad head, then a good packet
        do_reset();
        begin
            logic [255:0] b;
            b = {16{16'h1234}};
            b[127:112] = 16'h0000;
            send(mk_head(8'h11, 8'h22));
            send(b);
            send(mk_tail());
        end
        wait_idle();
        check_state("bodyerr");
        chk("bodyerr_last_code", 32'(err_code), 1);
        send_pkt(8'h44, 8'h22, 16'h0F0F);
        wait_idle();
        check_state("bodyerr_after");

        // Back-pressure
        do_reset();
        ready_mode = 2;
        send_pkt(8'h11, 8'h22, 16'hA5C3);
        begin
            int n = 0;
            while (!data_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("bp_valid_seen", 32'(data_valid), 1);
            repeat (5) begin
                @(negedge clk);
                chk("bp_valid_held", 32'(data_valid), 1);
                chk("bp_data_stable", 32'(data_out), 32'h0000A5C3);
                chk("bp_src_stable", 32'(src_out), 32'h11);
                chk("bp_no_pop", 32'(fifo_rd_en), 0);
            end
            ready_mode = 1;
            n = 0;
            while (!data_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("bp_pop_in_handshake", 32'(fifo_rd_en), 1);
        end
        wait_idle();
        check_state("bp");
        chk("bp_ok_is_1", 32'(pkt_ok_count), 1);

        // Resync after a garbage flit
        do_reset();
        begin
            logic [255:0] g;
            g = '0;
            g[0] = 1'b1;
            send(g);
        end
        wait_idle();
        chk("resync_code", 32'(err_code), 1);
        send_pkt(8'h55, 8'h22, 16'hBEEF);
        wait_idle();
        check_state("resync");
        chk("resync_ok_is_1", 32'(pkt_ok_count), 1);

        // Reset mid-packet
        do_reset();
        send(mk_head(8'h11, 8'h22));
        wait_idle();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        send({16{16'hA5C3}});
        send(mk_tail());
        @(negedge clk);
        check_reset_outputs("midrst");
        @(negedge clk);
        check_reset_outputs("midrst2");
        reset = 1'b1;
        wait_idle();
        check_state("midrst_stale");
        send_pkt(8'h66, 8'h22, 16'h1357);
        wait_idle();
        check_state("midrst_fresh");

        // Randomized traffic with bubbles and random sink stalls; counters saturate
        do_reset();
        bubble_en  = 1;
        ready_mode = 0;
        for (int k = 0; k < 60; k++) begin
            int kind;
            logic [7:0]   src;
            logic [15:0]  p;
            logic [255:0] f;
            kind = $urandom_range(0, 5);
            src  = 8'($urandom_range(0, 255));
            p    = 16'($urandom_range(0, 65535));
            case (kind)
                0, 1: send_pkt(src, 8'h22, p);
                2:    send_pkt(src, 8'h22 ^ 8'($urandom_range(1, 255)), p);
                3: begin
                    f = {16{p}};
                    f[16*$urandom_range(0, 15) +: 16] ^= 16'($urandom_range(1, 65535));
                    send(mk_head(src, 8'h22));
                    send(f);
                    send(mk_tail());
                end
                4: begin
                    f = mk_tail();
                    f[$urandom_range(0, 255)] ^= 1'b1;
                    send(mk_head(src, 8'h22));
                    send({16{p}});
                    send(f);
                end
                default: begin
                    for (int w = 0; w < 8; w++) f[32*w +: 32] = $urandom();
                    f[0] = 1'b1;
                    send(f);
                end
            endcase
            if (($urandom_range(0, 3) == 0)) wait_idle();
        end
        wait_idle();
        check_state("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
